// File: rtl/branch_pred_unit_pkg.sv
// branch_pred_unit_pkg: shared types and helpers for the tournament branch predictor
package branch_pred_unit_pkg;

    typedef enum logic [1:0] {
        PRED_NONE = 2'b00,
        PRED_LOC  = 2'b01,
        PRED_GLB  = 2'b10,
        PRED_BOTH = 2'b11
    } PreStrategy_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } BpCtr_e;

    // Tag field is sized for the smallest legal BTB index so any BTB_IDX_W fits
    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [29:0]      target;
        logic             is_jp;
    } BTB_ENTRY_s;

    // Saturating step of a 2-bit direction counter
    function automatic BpCtr_e ctr_next(BpCtr_e c, logic inc);
        return inc ? (c == ST  ? ST  : BpCtr_e'(c + 2'd1))
                   : (c == SNT ? SNT : BpCtr_e'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// branch_pred_unit_if: fetch lookup and EX training bundle between pipeline and predictor
interface branch_pred_unit_if;

    logic [31:0] i_if_pc;
    logic        o_pred_hit;
    logic        o_pred_taken;
    logic        o_glb_taken;
    logic        o_loc_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_upd_vld;
    logic [31:0] i_ex_pc;
    logic        i_ex_is_br;
    logic        i_ex_is_jp;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_glb_taken;
    logic        i_ex_loc_taken;
    logic        i_ex_mispred;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    modport master (
        output i_if_pc, i_ex_upd_vld, i_ex_pc, i_ex_is_br, i_ex_is_jp, i_ex_taken,
               i_ex_target, i_ex_glb_taken, i_ex_loc_taken, i_ex_mispred,
        input  o_pred_hit, o_pred_taken, o_glb_taken, o_loc_taken, o_pred_target,
               o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_if_pc, i_ex_upd_vld, i_ex_pc, i_ex_is_br, i_ex_is_jp, i_ex_taken,
               i_ex_target, i_ex_glb_taken, i_ex_loc_taken, i_ex_mispred,
        output o_pred_hit, o_pred_taken, o_glb_taken, o_loc_taken, o_pred_target,
               o_br_cnt, o_mispred_cnt
    );

endinterface

// File: rtl/branch_pred_unit_bp_ctr_table.sv
// bp_ctr_table: table of saturating 2-bit counters, async read, inc/dec write
module bp_ctr_table
    import branch_pred_unit_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output BpCtr_e           rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);

    BpCtr_e ctr [2**IDX_W];

    assign rd_ctr = ctr[rd_idx];

    // Counters start weakly not-taken and step toward the resolved outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= WNT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_inc);
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: tournament (local/gshare) direction predictor with BTB and perf counters
module branch_pred_unit
    import branch_pred_unit_pkg::*;
#(
    parameter int           BTB_IDX_W = 4,
    parameter int           BHT_IDX_W = 6,
    parameter int           GHR_W     = 6,
    parameter PreStrategy_e STRATEGY  = PRED_BOTH
) (
    input logic               i_clk,
    input logic               i_rst_n,
    branch_pred_unit_if.slave bp
);

    BTB_ENTRY_s           btb [2**BTB_IDX_W];
    BTB_ENTRY_s           entry;
    logic [BTB_IDX_W-1:0] btb_rd_idx;
    logic [BTB_IDX_W-1:0] btb_wr_idx;
    logic [BHT_IDX_W-1:0] loc_rd_idx;
    logic [BHT_IDX_W-1:0] loc_wr_idx;
    logic [GHR_W-1:0]     ghr;
    logic [GHR_W-1:0]     glb_rd_idx;
    logic [GHR_W-1:0]     glb_wr_idx;
    BpCtr_e               loc_ctr;
    BpCtr_e               glb_ctr;
    BpCtr_e               cho_ctr;
    logic                 hit;
    logic                 dir;
    logic                 br_upd;
    logic                 btb_wr;
    logic [31:0]          br_cnt;
    logic [31:0]          mispred_cnt;
    logic                 unused_target_lsb;

    assign btb_rd_idx = bp.i_if_pc[BTB_IDX_W+1:2];
    assign btb_wr_idx = bp.i_ex_pc[BTB_IDX_W+1:2];
    assign loc_rd_idx = bp.i_if_pc[BHT_IDX_W+1:2];
    assign loc_wr_idx = bp.i_ex_pc[BHT_IDX_W+1:2];
    assign glb_rd_idx = bp.i_if_pc[GHR_W+1:2] ^ ghr;
    assign glb_wr_idx = bp.i_ex_pc[GHR_W+1:2] ^ ghr;
    assign br_upd     = bp.i_ex_upd_vld & bp.i_ex_is_br;
    assign btb_wr     = bp.i_ex_upd_vld & bp.i_ex_taken & (bp.i_ex_is_br | bp.i_ex_is_jp);
    assign entry      = btb[btb_rd_idx];
    assign hit        = entry.valid && entry.tag == TAG_W'(bp.i_if_pc >> (BTB_IDX_W + 2));

    // Targets are word aligned, so the low bits of the resolved target are dropped
    assign unused_target_lsb = ^bp.i_ex_target[1:0];

    bp_ctr_table #(.IDX_W(BHT_IDX_W)) u_loc (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .rd_idx (loc_rd_idx),
        .rd_ctr (loc_ctr),
        .wr_en  (br_upd),
        .wr_idx (loc_wr_idx),
        .wr_inc (bp.i_ex_taken)
    );

    bp_ctr_table #(.IDX_W(GHR_W)) u_glb (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .rd_idx (glb_rd_idx),
        .rd_ctr (glb_ctr),
        .wr_en  (br_upd),
        .wr_idx (glb_wr_idx),
        .wr_inc (bp.i_ex_taken)
    );

    // Chooser moves toward gshare when it alone was right, toward local when it alone was right
    bp_ctr_table #(.IDX_W(BHT_IDX_W)) u_cho (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .rd_idx (loc_rd_idx),
        .rd_ctr (cho_ctr),
        .wr_en  (br_upd & (bp.i_ex_glb_taken != bp.i_ex_loc_taken)),
        .wr_idx (loc_wr_idx),
        .wr_inc (bp.i_ex_glb_taken == bp.i_ex_taken)
    );

    // Direction source for conditional branches that hit in the BTB
    always_comb begin
        dir = STRATEGY == PRED_NONE ? 1'b1 :
              STRATEGY == PRED_LOC  ? loc_ctr[1] :
              STRATEGY == PRED_GLB  ? glb_ctr[1] :
              cho_ctr[1] ? glb_ctr[1] : loc_ctr[1];
    end

    assign bp.o_pred_hit    = hit;
    assign bp.o_pred_taken  = hit && (entry.is_jp || dir);
    assign bp.o_glb_taken   = glb_ctr[1];
    assign bp.o_loc_taken   = loc_ctr[1];
    assign bp.o_pred_target = hit ? {entry.target, 2'b00} : bp.i_if_pc + 32'd4;
    assign bp.o_br_cnt      = br_cnt;
    assign bp.o_mispred_cnt = mispred_cnt;

    // BTB allocates on every taken branch/jump, overwriting whatever aliases into the slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2**BTB_IDX_W; i++) btb[i] <= '0;
        end else if (btb_wr) begin
            btb[btb_wr_idx] <= '{valid:  1'b1,
                                 tag:    TAG_W'(bp.i_ex_pc >> (BTB_IDX_W + 2)),
                                 target: bp.i_ex_target[31:2],
                                 is_jp:  bp.i_ex_is_jp};
        end
    end

    // Non-speculative global history: shifted only by resolved conditional branches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ghr <= '0;
        else if (br_upd) ghr <= {ghr[GHR_W-2:0], bp.i_ex_taken};
    end

    // Evaluation counters hold at all-ones rather than wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (br_upd && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
            if (bp.i_ex_upd_vld && bp.i_ex_mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed self-checking bench over all four direction strategies
module tb_branch_pred_unit;
    import branch_pred_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        upd_vld = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        is_br = 1'b0;
    logic        is_jp = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        glb_t = 1'b0;
    logic        loc_t = 1'b0;
    logic        mispred = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    branch_pred_unit_if ifn ();
    branch_pred_unit_if ifl ();
    branch_pred_unit_if ifg ();
    branch_pred_unit_if ifb ();

`define TB_DRIVE(x) \
    assign x.i_if_pc = pc; assign x.i_ex_upd_vld = upd_vld; assign x.i_ex_pc = ex_pc; \
    assign x.i_ex_is_br = is_br; assign x.i_ex_is_jp = is_jp; assign x.i_ex_taken = ex_taken; \
    assign x.i_ex_target = ex_target; assign x.i_ex_glb_taken = glb_t; \
    assign x.i_ex_loc_taken = loc_t; assign x.i_ex_mispred = mispred;

    `TB_DRIVE(ifn)
    `TB_DRIVE(ifl)
    `TB_DRIVE(ifg)
    `TB_DRIVE(ifb)

    branch_pred_unit #(.STRATEGY(PRED_NONE)) dut_n (.i_clk(clk), .i_rst_n(rst_n), .bp(ifn));
    branch_pred_unit #(.STRATEGY(PRED_LOC))  dut_l (.i_clk(clk), .i_rst_n(rst_n), .bp(ifl));
    branch_pred_unit #(.STRATEGY(PRED_GLB))  dut_g (.i_clk(clk), .i_rst_n(rst_n), .bp(ifg));
    branch_pred_unit #(.STRATEGY(PRED_BOTH)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bp(ifb));

    always @(posedge clk) if (upd_vld) assert (!(is_br && is_jp)) else $error("illegal update: branch and jump together");

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1);
    end

    task automatic upd(input logic [31:0] p, input logic br, input logic jp, input logic t,
                       input logic [31:0] tg, input logic g, input logic l, input logic m);
        ex_pc = p; is_br = br; is_jp = jp; ex_taken = t; ex_target = tg;
        glb_t = g; loc_t = l; mispred = m; upd_vld = 1'b1;
        @(posedge clk); #1;
        upd_vld = 1'b0;
    endtask

    task automatic do_reset();
        upd_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        pc = 32'h100; rst_n = 1'b0; #1;
        checks++; if (ifb.o_pred_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0h exp=0", ifb.o_pred_hit); end
        checks++; if (ifb.o_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0h exp=0", ifb.o_pred_taken); end
        checks++; if (ifn.o_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken_none got=%0h exp=0", ifn.o_pred_taken); end
        checks++; if (ifb.o_pred_target !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=00000104", ifb.o_pred_target); end
        checks++; if (ifb.o_glb_taken !== 1'b0) begin failures++; $display("FAIL reset_glb got=%0h exp=0", ifb.o_glb_taken); end
        checks++; if (ifb.o_loc_taken !== 1'b0) begin failures++; $display("FAIL reset_loc got=%0h exp=0", ifb.o_loc_taken); end
        checks++; if (ifb.o_br_cnt !== 32'h0) begin failures++; $display("FAIL reset_br_cnt got=%0d exp=0", ifb.o_br_cnt); end
        checks++; if (ifb.o_mispred_cnt !== 32'h0) begin failures++; $display("FAIL reset_mispred_cnt got=%0d exp=0", ifb.o_mispred_cnt); end
    endtask

    task automatic test_jal();
        do_reset();
        upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        pc = 32'h100; #1;
        checks++; if (ifb.o_pred_hit !== 1'b1) begin failures++; $display("FAIL jal_hit got=%0h exp=1", ifb.o_pred_hit); end
        checks++; if (ifb.o_pred_target !== 32'h200) begin failures++; $display("FAIL jal_target got=%h exp=00000200", ifb.o_pred_target); end
        checks++; if (ifn.o_pred_taken !== 1'b1) begin failures++; $display("FAIL jal_taken_none got=%0h exp=1", ifn.o_pred_taken); end
        checks++; if (ifl.o_pred_taken !== 1'b1) begin failures++; $display("FAIL jal_taken_loc got=%0h exp=1", ifl.o_pred_taken); end
        checks++; if (ifg.o_pred_taken !== 1'b1) begin failures++; $display("FAIL jal_taken_glb got=%0h exp=1", ifg.o_pred_taken); end
        checks++; if (ifb.o_pred_taken !== 1'b1) begin failures++; $display("FAIL jal_taken_both got=%0h exp=1", ifb.o_pred_taken); end
        checks++; if (ifb.o_br_cnt !== 32'h0) begin failures++; $display("FAIL jal_br_cnt got=%0d exp=0", ifb.o_br_cnt); end
        // GHR still 0 here: gshare[0x29] trains, GHR becomes 1, so pc 0x1A0 (idx 0x28) reads 0x28^1=0x29
        upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        pc = 32'h1A0; #1;
        checks++; if (ifb.o_glb_taken !== 1'b1) begin failures++; $display("FAIL jal_ghr_glb got=%0h exp=1", ifb.o_glb_taken); end
        checks++; if (ifb.o_pred_hit !== 1'b0) begin failures++; $display("FAIL jal_ghr_miss got=%0h exp=0", ifb.o_pred_hit); end
    endtask

    task automatic test_pred_loc();
        do_reset();
        upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        pc = 32'h1A4; #1;
        checks++; if (ifl.o_loc_taken !== 1'b1) begin failures++; $display("FAIL loc_t1_loc got=%0h exp=1", ifl.o_loc_taken); end
        checks++; if (ifl.o_pred_taken !== 1'b1) begin failures++; $display("FAIL loc_t1_taken got=%0h exp=1", ifl.o_pred_taken); end
        checks++; if (ifl.o_pred_target !== 32'h300) begin failures++; $display("FAIL loc_t1_target got=%h exp=00000300", ifl.o_pred_target); end
        checks++; if (ifl.o_glb_taken !== 1'b0) begin failures++; $display("FAIL loc_t1_glb got=%0h exp=0", ifl.o_glb_taken); end
        upd(32'h1A4, 1'b1, 1'b0, 1'b0, 32'h1A8, 1'b1, 1'b1, 1'b1);
        upd(32'h1A4, 1'b1, 1'b0, 1'b0, 32'h1A8, 1'b0, 1'b0, 1'b0);
        checks++; if (ifl.o_loc_taken !== 1'b0) begin failures++; $display("FAIL loc_nt_loc got=%0h exp=0", ifl.o_loc_taken); end
        checks++; if (ifl.o_pred_taken !== 1'b0) begin failures++; $display("FAIL loc_nt_taken got=%0h exp=0", ifl.o_pred_taken); end
        checks++; if (ifl.o_pred_hit !== 1'b1) begin failures++; $display("FAIL loc_nt_hit got=%0h exp=1", ifl.o_pred_hit); end
        checks++; if (ifl.o_pred_target !== 32'h300) begin failures++; $display("FAIL loc_nt_target got=%h exp=00000300", ifl.o_pred_target); end
        checks++; if (ifl.o_br_cnt !== 32'd3) begin failures++; $display("FAIL loc_br_cnt got=%0d exp=3", ifl.o_br_cnt); end
        checks++; if (ifl.o_mispred_cnt !== 32'd2) begin failures++; $display("FAIL loc_mispred_cnt got=%0d exp=2", ifl.o_mispred_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        pc = 32'h1A4;
        repeat (3) upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        upd(32'h1A4, 1'b1, 1'b0, 1'b0, 32'h1A8, 1'b0, 1'b0, 1'b0);
        checks++; if (ifl.o_loc_taken !== 1'b1) begin failures++; $display("FAIL sat_st_loc got=%0h exp=1", ifl.o_loc_taken); end
        upd(32'h1A4, 1'b1, 1'b0, 1'b0, 32'h1A8, 1'b0, 1'b0, 1'b0);
        checks++; if (ifl.o_loc_taken !== 1'b0) begin failures++; $display("FAIL sat_wnt_loc got=%0h exp=0", ifl.o_loc_taken); end
    endtask

    task automatic test_alias();
        do_reset();
        upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        upd(32'h140, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
        pc = 32'h100; #1;
        checks++; if (ifb.o_pred_hit !== 1'b0) begin failures++; $display("FAIL alias_old_hit got=%0h exp=0", ifb.o_pred_hit); end
        checks++; if (ifb.o_pred_target !== 32'h104) begin failures++; $display("FAIL alias_old_target got=%h exp=00000104", ifb.o_pred_target); end
        checks++; if (ifn.o_pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_taken got=%0h exp=0", ifn.o_pred_taken); end
        pc = 32'h140; #1;
        checks++; if (ifb.o_pred_hit !== 1'b1) begin failures++; $display("FAIL alias_new_hit got=%0h exp=1", ifb.o_pred_hit); end
        checks++; if (ifb.o_pred_target !== 32'h180) begin failures++; $display("FAIL alias_new_target got=%h exp=00000180", ifb.o_pred_target); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pc = 32'h1A4;
        ex_pc = 32'h1A4; is_br = 1'b1; is_jp = 1'b0; ex_taken = 1'b1; ex_target = 32'h300;
        glb_t = 1'b0; loc_t = 1'b0; mispred = 1'b1; upd_vld = 1'b1;
        #1;
        checks++; if (ifl.o_loc_taken !== 1'b0) begin failures++; $display("FAIL same_pre_loc got=%0h exp=0", ifl.o_loc_taken); end
        checks++; if (ifl.o_pred_hit !== 1'b0) begin failures++; $display("FAIL same_pre_hit got=%0h exp=0", ifl.o_pred_hit); end
        @(posedge clk); #1;
        upd_vld = 1'b0;
        checks++; if (ifl.o_loc_taken !== 1'b1) begin failures++; $display("FAIL same_post_loc got=%0h exp=1", ifl.o_loc_taken); end
        checks++; if (ifl.o_pred_taken !== 1'b1) begin failures++; $display("FAIL same_post_taken got=%0h exp=1", ifl.o_pred_taken); end
    endtask

    task automatic test_chooser();
        do_reset();
        // local: WNT->WT->ST; gshare 0x29, 0x28 trained; chooser WNT->WT->ST; lookup reads gshare 0x2A (WNT)
        repeat (2) upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        pc = 32'h1A4; #1;
        checks++; if (ifb.o_loc_taken !== 1'b1) begin failures++; $display("FAIL cho_loc got=%0h exp=1", ifb.o_loc_taken); end
        checks++; if (ifb.o_glb_taken !== 1'b0) begin failures++; $display("FAIL cho_glb got=%0h exp=0", ifb.o_glb_taken); end
        checks++; if (ifb.o_pred_taken !== 1'b0) begin failures++; $display("FAIL cho_taken_both got=%0h exp=0", ifb.o_pred_taken); end
        checks++; if (ifl.o_pred_taken !== 1'b1) begin failures++; $display("FAIL cho_taken_loc got=%0h exp=1", ifl.o_pred_taken); end
        checks++; if (ifg.o_pred_taken !== 1'b0) begin failures++; $display("FAIL cho_taken_glb got=%0h exp=0", ifg.o_pred_taken); end
        checks++; if (ifn.o_pred_taken !== 1'b1) begin failures++; $display("FAIL cho_taken_none got=%0h exp=1", ifn.o_pred_taken); end
    endtask

    task automatic test_counters();
        do_reset();
        upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        ex_pc = 32'h1A4; is_br = 1'b1; mispred = 1'b1; upd_vld = 1'b0;
        @(posedge clk); #1;
        upd(32'h1A4, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        checks++; if (ifb.o_br_cnt !== 32'd3) begin failures++; $display("FAIL cnt_br got=%0d exp=3", ifb.o_br_cnt); end
        checks++; if (ifb.o_mispred_cnt !== 32'd1) begin failures++; $display("FAIL cnt_mispred got=%0d exp=1", ifb.o_mispred_cnt); end
        upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
        checks++; if (ifb.o_br_cnt !== 32'd3) begin failures++; $display("FAIL cnt_jp_br got=%0d exp=3", ifb.o_br_cnt); end
        checks++; if (ifb.o_mispred_cnt !== 32'd2) begin failures++; $display("FAIL cnt_jp_mispred got=%0d exp=2", ifb.o_mispred_cnt); end
    endtask

    task automatic test_async_reset();
        pc = 32'h1A4; #1;
        checks++; if (ifl.o_pred_hit !== 1'b1) begin failures++; $display("FAIL ar_pre_hit got=%0h exp=1", ifl.o_pred_hit); end
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        checks++; if (ifl.o_pred_hit !== 1'b0) begin failures++; $display("FAIL ar_hit got=%0h exp=0", ifl.o_pred_hit); end
        checks++; if (ifl.o_pred_taken !== 1'b0) begin failures++; $display("FAIL ar_taken got=%0h exp=0", ifl.o_pred_taken); end
        checks++; if (ifl.o_pred_target !== 32'h1A8) begin failures++; $display("FAIL ar_target got=%h exp=000001a8", ifl.o_pred_target); end
        checks++; if (ifl.o_loc_taken !== 1'b0) begin failures++; $display("FAIL ar_loc got=%0h exp=0", ifl.o_loc_taken); end
        checks++; if (ifl.o_br_cnt !== 32'h0) begin failures++; $display("FAIL ar_br_cnt got=%0d exp=0", ifl.o_br_cnt); end
        checks++; if (ifl.o_mispred_cnt !== 32'h0) begin failures++; $display("FAIL ar_mispred_cnt got=%0d exp=0", ifl.o_mispred_cnt); end
        ex_pc = 32'h1A4; is_br = 1'b1; is_jp = 1'b0; ex_taken = 1'b1; ex_target = 32'h300;
        mispred = 1'b1; upd_vld = 1'b1;
        @(posedge clk); #1;
        upd_vld = 1'b0;
        checks++; if (ifl.o_pred_hit !== 1'b0) begin failures++; $display("FAIL ar_upd_hit got=%0h exp=0", ifl.o_pred_hit); end
        checks++; if (ifl.o_br_cnt !== 32'h0) begin failures++; $display("FAIL ar_upd_br_cnt got=%0d exp=0", ifl.o_br_cnt); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_jal();
        test_pred_loc();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_chooser();
        test_counters();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Tournament branch predictor and BTB for the 5-stage RV32I pipeline.
- Looks up the IF-stage PC combinationally. Produces the IF_ID_CReg_s prediction fields (is_pred_taken, is_pred_hit, is_glb_taken, is_loc_taken) and the predicted target. These drive PC_IF_PRED selection.
- Trains its tables from branches and jumps resolved in EX. Keeps evaluation counters.

Parameters:
- BTB_IDX_W, 4, log2 of BTB entries (16); index = pc[BTB_IDX_W+1:2], tag = pc[31:BTB_IDX_W+2]
- BHT_IDX_W, 6, log2 of local-counter and chooser entries; index = pc[BHT_IDX_W+1:2]
- GHR_W, 6, global history length; gshare table has 2^GHR_W entries
- STRATEGY, PRED_BOTH, PreStrategy_e selecting the direction source

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_if_pc  in  32  fetch PC
- o_pred_hit  out  1  BTB hit for i_if_pc
- o_pred_taken  out  1  predicted taken
- o_glb_taken  out  1  gshare counter MSB
- o_loc_taken  out  1  local counter MSB
- o_pred_target  out  32  BTB target on hit, else i_if_pc+4
- i_ex_upd_vld  in  1  one-cycle pulse: valid, unflushed branch/jump resolved in EX
- i_ex_pc  in  32  PC of resolved instruction
- i_ex_is_br  in  1  conditional branch
- i_ex_is_jp  in  1  JAL/JALR
- i_ex_taken  in  1  actual outcome
- i_ex_target  in  32  actual target (ALU result)
- i_ex_glb_taken  in  1  o_glb_taken carried through pipeline
- i_ex_loc_taken  in  1  o_loc_taken carried through pipeline
- i_ex_mispred  in  1  EX detected misprediction (direction or target)
- o_br_cnt  out  32  resolved conditional branches
- o_mispred_cnt  out  32  mispredictions

Behaviour:
- Lookup is purely combinational from i_if_pc and table state; zero-cycle latency.
- BTB hit = valid & tag match. A BTB entry holds {valid, tag, target[31:2], is_jp}; target[1:0] reads 0.
- loc = local_ctr[pc idx][1]. glb = gshare_ctr[pc[GHR_W+1:2] ^ GHR][1]. choose_glb = chooser[pc idx][1].
- o_pred_taken:
  - 0 if no hit.
  - 1 if hit and entry is_jp.
  - Otherwise by STRATEGY: PRED_NONE -> 1; PRED_LOC -> loc; PRED_GLB -> glb; PRED_BOTH -> choose_glb ? glb : loc.
- o_glb_taken and o_loc_taken are driven regardless of hit.
- Update, at the rising edge when i_ex_upd_vld=1:
  - BTB: if i_ex_taken, write entry {1, tag, i_ex_target, i_ex_is_jp} at i_ex_pc index (overwrites any alias). Not-taken leaves the BTB unchanged.
  - Branch only (i_ex_is_br): local counter at i_ex_pc idx and gshare counter at pc idx ^ current GHR saturate +1 if taken, -1 if not (00..11).
  - Chooser trains only if i_ex_glb_taken != i_ex_loc_taken: +1 if glb was correct, -1 if loc was correct.
  - GHR <= {GHR[GHR_W-2:0], i_ex_taken}.
  - Jumps never touch counters or GHR.
- GHR is non-speculative. The gshare update index uses the GHR at update time; a mismatch with the lookup index is accepted.
- Simultaneous lookup and update of the same entry: lookup sees pre-update state; the new state is visible next cycle.
- i_ex_is_br and i_ex_is_jp both 1 is illegal; the bench asserts it never happens. Updates with both 0 are ignored.
- Counters:
  - o_br_cnt +1 on upd_vld & is_br.
  - o_mispred_cnt +1 on upd_vld & i_ex_mispred.
  - Both saturate at 32'hFFFF_FFFF.
- Reset, asynchronous, takes effect immediately, including mid-update:
  - all BTB valid=0; local, gshare and chooser counters = 2'b01 (weakly not-taken / weakly local); GHR=0; both perf counters=0.
  - Hence outputs: hit=0, taken=0, target=i_if_pc+4.

Decomposition:
- singlecycle_pkg gains:
  - BpCtr_e (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11);
  - BTB_ENTRY_s packed struct.
- PreStrategy_e is already in the package and is reused.
- Sub-module bp_ctr_table (parameter IDX_W): 2^IDX_W saturating 2-bit counters, one async read port, one inc/dec write port, reset to WNT. Instantiated three times.

Test Plan:
- Reset, i_if_pc=0x0000_0100 -> hit=0, taken=0, target=0x0000_0104, glb=loc=0, counters 0.
- JAL update pc=0x100, target=0x200, taken=1, is_jp=1 -> next cycle lookup 0x100: hit=1, taken=1, target=0x200 for all four STRATEGY values; GHR unchanged.
- STRATEGY=PRED_LOC, branch pc=0x1A4:
  - taken update -> loc=1, taken=1, target=i_ex_target;
  - two not-taken updates -> loc=0, taken=0, hit=1;
  - o_br_cnt=3.
- Alias: BTB holds 0x100; taken update at 0x140 (same index 0) -> lookup 0x100 hit=0; lookup 0x140 hit=1.
- Same-cycle: lookup 0x1A4 while updating it from WNT to WT -> o_loc_taken=0 that cycle, 1 next cycle.
- PRED_BOTH, glb correct / loc wrong twice -> chooser 11 and taken follows glb. Then 3 updates with 1 mispred -> counts 3/1. Drop i_rst_n mid-cycle -> outputs reset immediately.
